// File: rtl/truth_table_sweeper.sv
// Drives every input combination into a small combinational CUT, holds each one
// for SETTLE_CYC cycles and records the CUT output into a truth-table word.
module truth_table_sweeper #(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 x_in,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 table_valid,
  output logic [1:0]           dbg_state
);

  localparam int WCW = $clog2(SETTLE_CYC + 1);
  localparam logic [WCW-1:0]  WC_LAST  = WCW'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  logic [WCW-1:0]      r_wcnt;
  logic [N_IN-1:0]     r_vec;
  logic                r_busy;
  logic                r_done;
  logic [2**N_IN-1:0]  r_table;
  logic                r_valid;

  // Handshake: start is a level sampled only in IDLE; abort cancels a sweep in
  // SETTLE and also vetoes a same-cycle start in IDLE. done is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_table <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state <= S_SETTLE;
            r_vec   <= '0;
            r_wcnt  <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_table <= '0;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            // Cancel wins over a sample falling on the same edge.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_vec   <= '0;
            r_wcnt  <= '0;
          end else if (r_wcnt == WC_LAST) begin
            r_table[r_vec] <= x_in;
            r_wcnt         <= '0;
            if (r_vec == VEC_LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_valid <= 1'b1;
            end else begin
              r_vec <= r_vec + 1'b1;
            end
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_vec   <= '0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_vec   <= '0;
        end
      endcase
    end
  end

  assign vec_out     = r_vec;
  assign busy        = r_busy;
  assign done        = r_done;
  assign table_out   = r_table;
  assign table_valid = r_valid;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a behavioural CUT feeds x_in, and expected
// tables come from evaluating that CUT over every input combination.
module tb_truth_table_sweeper;
  localparam int N_IN = 3;
  localparam int SC   = 4;
  localparam int NV   = 2**N_IN;
  localparam int LAT  = NV * SC;
  localparam int WIN  = LAT + 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic start, abort, x_in, busy, done, table_valid;
  logic [N_IN-1:0] vec_out;
  logic [NV-1:0]   table_out;
  logic [1:0]      dbg_state;

  logic start1, abort1, x_in1, busy1, done1, valid1;
  logic [N_IN-1:0] vec1;
  logic [NV-1:0]   tbl1;
  logic [1:0]      dbg1;

  int         mode;
  logic [7:0] lut;

  int n_checks = 0;
  int n_err    = 0;
  logic [NV-1:0] exp_q[$];

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_in(x_in),
    .vec_out(vec_out), .busy(busy), .done(done), .table_out(table_out),
    .table_valid(table_valid), .dbg_state(dbg_state)
  );

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .x_in(x_in1),
    .vec_out(vec1), .busy(busy1), .done(done1), .table_out(tbl1),
    .table_valid(valid1), .dbg_state(dbg1)
  );

  // Behavioural CUT: 0 = X = A&B | ~B&C, 1 = tied high, 2 = tied low, 3 = lookup
  function automatic logic cut_fn(input logic [2:0] v, input int m, input logic [7:0] l);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    case (m)
      0:       return (a & b) | (~b & c);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return l[v];
    endcase
  endfunction

  function automatic logic [NV-1:0] model_table(input int m, input logic [7:0] l, input int upto);
    logic [NV-1:0] t;
    t = '0;
    for (int i = 0; i < upto; i++) t[i] = cut_fn(3'(i), m, l);
    return t;
  endfunction

  always_comb x_in  = cut_fn(vec_out, mode, lut);
  always_comb x_in1 = cut_fn(vec1, 0, 8'h00);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one start pulse, optional re-start / abort at cycle c (counted from
  // the start edge), watches a fixed window and scoreboards every done pulse
  task automatic sweep_observe(input int restart_at, input int abort_at,
                               output int done_cyc, output int n_done);
    logic [NV-1:0] e;
    done_cyc = -1;
    n_done   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= WIN; c++) begin
      start = (c == restart_at);
      abort = (c == abort_at);
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (c == 1 && abort_at != 1) begin
        chk("busy_in_sweep", busy, 1);
        chk("valid_in_sweep", table_valid, 0);
      end
      if (c == abort_at && c <= LAT) begin
        chk("abort_busy", busy, 0);
        chk("abort_vec", vec_out, 0);
        chk("abort_valid", table_valid, 0);
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", c);
        end else begin
          e = exp_q.pop_front();
          chk("table_out_at_done", table_out, e);
          chk("busy_at_done", busy, 0);
          chk("valid_at_done", table_valid, 1);
          chk("vec_at_done", vec_out, NV - 1);
        end
      end
    end
    chk("busy_after_window", busy, 0);
    chk("pending_q", exp_q.size(), 0);
    exp_q.delete();
  endtask

  typedef struct {
    int         m;
    logic [7:0] l;
    logic [7:0] exp_tbl;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int dc, nd, aat;
    bit aborted;
    logic [NV-1:0] et;

    vecs[0] = '{0, 8'h00, 8'hE2};
    vecs[1] = '{1, 8'h00, 8'hFF};
    vecs[2] = '{2, 8'h00, 8'h00};
    vecs[3] = '{3, 8'h5A, 8'h5A};
    vecs[4] = '{3, 8'h81, 8'h81};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    mode = 0; lut = 8'h00;
    #2;
    chk("rst_vec", vec_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_table", table_out, 0);
    chk("rst_valid", table_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", busy, 0);

    // table-driven sweeps: gate CUT, tied high, tied low, lookup patterns
    foreach (vecs[k]) begin
      mode = vecs[k].m;
      lut  = vecs[k].l;
      exp_q.push_back(model_table(mode, lut, NV));
      chk($sformatf("model_vs_table_%0d", k), model_table(mode, lut, NV), vecs[k].exp_tbl);
      sweep_observe(0, 0, dc, nd);
      chk($sformatf("latency_%0d", k), dc, LAT);
      chk($sformatf("n_done_%0d", k), nd, 1);
      chk($sformatf("table_held_%0d", k), table_out, vecs[k].exp_tbl);
      chk($sformatf("valid_held_%0d", k), table_valid, 1);
    end

    // start re-pulsed mid-sweep is ignored
    mode = 0;
    exp_q.push_back(8'hE2);
    sweep_observe(10, 0, dc, nd);
    chk("restart_latency", dc, LAT);
    chk("restart_n_done", nd, 1);
    chk("restart_table", table_out, 8'hE2);

    // abort at cycle 13, then a clean sweep
    sweep_observe(0, 13, dc, nd);
    chk("abort_n_done", nd, 0);
    chk("abort_valid_end", table_valid, 0);
    exp_q.push_back(8'hE2);
    sweep_observe(0, 0, dc, nd);
    chk("post_abort_latency", dc, LAT);
    chk("post_abort_table", table_out, 8'hE2);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_valid", table_valid, 1);

    // asynchronous reset between edges mid-sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("pre_reset_table", table_out, model_table(0, 8'h00, 5));
    chk("pre_reset_vec", vec_out, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vec", vec_out, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_table", table_out, 0);
    chk("async_rst_valid", table_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || vec_out !== '0) begin
        n_err++;
        $display("FAIL post_reset_idle: busy=%b done=%b vec=%0d, required 0/0/0", busy, done, vec_out);
      end
      n_checks++;
    end

    // one-cycle settle variant: vector steps every cycle
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("sc1_vec_0", vec1, 0);
    for (int c = 1; c < NV; c++) begin
      tick();
      chk($sformatf("sc1_vec_%0d", c), vec1, c);
      chk($sformatf("sc1_nodone_%0d", c), done1, 0);
    end
    tick();
    chk("sc1_done", done1, 1);
    chk("sc1_table", tbl1, model_table(0, 8'h00, NV));
    chk("sc1_valid", valid1, 1);
    tick();
    chk("sc1_done_pulse", done1, 0);

    // randomized CUT lookup tables and abort timing against the model
    for (int r = 0; r < 12; r++) begin
      mode = 3;
      lut  = 8'($urandom);
      repeat ($urandom_range(0, 4)) tick();
      aat = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, WIN)) : 0;
      aborted = (aat >= 1 && aat <= LAT);
      et = model_table(mode, lut, NV);
      if (!aborted) exp_q.push_back(et);
      sweep_observe(0, aat, dc, nd);
      if (aborted) begin
        chk($sformatf("rnd_abort_nd_%0d", r), nd, 0);
        chk($sformatf("rnd_abort_valid_%0d", r), table_valid, 0);
      end else begin
        chk($sformatf("rnd_lat_%0d", r), dc, LAT);
        chk($sformatf("rnd_table_%0d", r), table_out, et);
        chk($sformatf("rnd_valid_%0d", r), table_valid, 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule
